// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 8 x 16-bit register file and the
// write-back path that feeds it.
//   DW, AW, NREG        : data width, register select width, register count
//   REQ_ALU/LSU/PC      : fixed requester slot of each write-back source
//   reg_sel_t           : register select
//   reg_data_t          : register data word
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 1 << AW;

  // Write-back requester slots on the arbiter (lower slot is not
  // inherently higher priority; the round-robin pointer decides).
  localparam int REQ_ALU   = 0;
  localparam int REQ_LSU   = 1;
  localparam int REQ_PC    = 2;
  localparam int NREQ_CPU  = 3;

  typedef logic [AW-1:0] reg_sel_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered search pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request (NREQ bits)
//   advance    : the currently granted request was consumed this cycle
//   grant      : one-hot grant, combinational from req and the pointer
//   ptr_dbg    : current search start (round-robin pointer)
//
// The search starts at ptr and wraps modulo NREQ; the first requesting
// slot wins. When the grant is consumed the pointer moves to the slot just
// after the winner so it becomes lowest priority next time. With no
// request the pointer holds. The grant is forced low while reset is
// asserted so nothing can be consumed during reset.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr_dbg
);

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] grant_d;
  logic [PW-1:0]   win_idx;
  logic            win_found;

  // Wrapped search from the pointer. The sum is one bit wider than the
  // pointer so ptr + k never overflows before the modulo correction.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant_d   = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!win_found && req[idx]) begin
        win_found     = 1'b1;
        win_idx       = idx;
        grant_d[idx]  = 1'b1;
      end
    end
  end

  assign grant = rst_n ? grant_d : '0;

  // Next pointer: slot after the winner, wrapped.
  always_comb begin
    logic [PW:0] nxt;
    ptr_d = ptr_q;
    nxt   = {1'b0, win_idx} + (PW+1)'(1);
    if (nxt >= (PW+1)'(NREQ)) begin
      nxt = '0;
    end
    if (advance && win_found) begin
      ptr_d = nxt[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_dbg = ptr_q;

endmodule : rr_arbiter

// File: rtl/reg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wb_arbiter
// Write-back arbiter and in-flight write scoreboard for the register file.
// Shares the single register-file write port between NREQ write-back
// requesters and flags read-after-write / write-after-write hazards for
// the decode stage.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   REQ_V    [NREQ]     : per-requester write valid
//   REQ_WS   [NREQ*AW]  : per-requester destination, slot i at [i*AW +: AW]
//   REQ_DATA [NREQ*DW]  : per-requester data, slot i at [i*DW +: DW]
//   REQ_RDY  [NREQ]     : one-hot grant
//   ISSUE_V, ISSUE_WS   : decode issuing an instruction writing ISSUE_WS
//   RS1, RS2            : read selects presented to the register file
//   HAZ1, HAZ2          : RS1 / RS2 has a write in flight
//   STALL               : issue blocked (WAW on ISSUE_WS or HAZ1/HAZ2)
//   WS, WE, IN          : registered register-file write port
//   ptr_dbg             : round-robin pointer
//   busy_dbg [NREG]     : scoreboard contents
//
// Handshake: a requester raises REQ_V[i] with REQ_WS/REQ_DATA and holds
// all three stable until it sees REQ_RDY[i]; the transfer happens on the
// rising edge where REQ_V[i] & REQ_RDY[i]. REQ_RDY is combinational from
// REQ_V and the pointer, and a request is never withdrawn.
//
// Write timing: accept at edge n -> WE/WS/IN valid during cycle n+1 ->
// register file writes and busy clears at the end of n+1, so a read in
// n+2 sees the new value with no hazard flagged.
// -----------------------------------------------------------------------------
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = NREQ_CPU,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    REQ_V,
  input  logic [NREQ*AW-1:0] REQ_WS,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    REQ_RDY,
  input  logic               ISSUE_V,
  input  reg_sel_t           ISSUE_WS,
  input  reg_sel_t           RS1,
  input  reg_sel_t           RS2,
  output logic               HAZ1,
  output logic               HAZ2,
  output logic               STALL,
  output reg_sel_t           WS,
  output logic               WE,
  output reg_data_t          IN,
  output logic [PW-1:0]      ptr_dbg,
  output logic [NREG-1:0]    busy_dbg
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] grant;
  logic            accept;
  reg_sel_t        sel_ws;
  reg_data_t       sel_data;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (REQ_V),
    .advance (accept),
    .grant   (grant),
    .ptr_dbg (ptr_dbg)
  );

  assign REQ_RDY = grant;

  // Grant is one-hot, so an OR of the masked slots is the selected payload.
  always_comb begin
    accept   = |(REQ_V & grant);
    sel_ws   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_ws   = sel_ws   | REQ_WS[i*AW +: AW];
        sel_data = sel_data | REQ_DATA[i*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  logic      we_q, we_d;
  reg_sel_t  ws_q, ws_d;
  reg_data_t in_q, in_d;

  // A write to R0 is still consumed by the handshake but never reaches
  // the register file.
  always_comb begin
    we_d = 1'b0;
    ws_d = ws_q;
    in_d = in_q;
    if (accept) begin
      we_d = (sel_ws != '0);
      ws_d = sel_ws;
      in_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      ws_q <= '0;
      in_q <= '0;
    end else begin
      we_q <= we_d;
      ws_q <= ws_d;
      in_q <= in_d;
    end
  end

  assign WE = we_q;
  assign WS = ws_q;
  assign IN = in_q;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] busy_q, busy_d;
  logic            issue_take;

  assign HAZ1  = busy_q[RS1];
  assign HAZ2  = busy_q[RS2];
  // Blocking WAW keeps at most one outstanding write per register, so a
  // single busy bit per register is enough.
  assign STALL = ISSUE_V & (busy_q[ISSUE_WS] | HAZ1 | HAZ2);

  assign issue_take = ISSUE_V & ~STALL & (ISSUE_WS != '0);

  // Clear is applied before set so a new issue to the register retiring
  // on the same edge keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[ws_q] = 1'b0;
    end
    if (issue_take) begin
      busy_d[ISSUE_WS] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_dbg = busy_q;

endmodule : reg_wb_arbiter

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
  import cpu_pkg::*;

  localparam int NREQ = 3;
  localparam int PW   = 2;
  localparam int EW   = 16 + AW + DW;   // {cycle, ws, data}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    REQ_V = '0;
  logic [NREQ*AW-1:0] REQ_WS = '0;
  logic [NREQ*DW-1:0] REQ_DATA = '0;
  logic [NREQ-1:0]    REQ_RDY;
  logic               ISSUE_V = 1'b0;
  logic [AW-1:0]      ISSUE_WS = '0;
  logic [AW-1:0]      RS1 = '0;
  logic [AW-1:0]      RS2 = '0;
  logic               HAZ1, HAZ2, STALL;
  logic [AW-1:0]      WS;
  logic               WE;
  logic [DW-1:0]      IN;
  logic [PW-1:0]      ptr_dbg;
  logic [NREG-1:0]    busy_dbg;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .REQ_V    (REQ_V),
    .REQ_WS   (REQ_WS),
    .REQ_DATA (REQ_DATA),
    .REQ_RDY  (REQ_RDY),
    .ISSUE_V  (ISSUE_V),
    .ISSUE_WS (ISSUE_WS),
    .RS1      (RS1),
    .RS2      (RS2),
    .HAZ1     (HAZ1),
    .HAZ2     (HAZ2),
    .STALL    (STALL),
    .WS       (WS),
    .WE       (WE),
    .IN       (IN),
    .ptr_dbg  (ptr_dbg),
    .busy_dbg (busy_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file emulation driven by the DUT write port.
  logic [DW-1:0] rf_dut [NREG] = '{default: '0};
  always @(posedge clk) begin
    if (WE === 1'b1) rf_dut[WS] <= IN;
  end

  // ---------------------------------------------------------------------------
  // Reference model state and stimulus state
  // ---------------------------------------------------------------------------
  int              checks = 0;
  int              failures = 0;
  int              ptr_m = 0;
  bit [NREG-1:0]   busy_m = '0;
  logic [DW-1:0]   rf_m [NREG] = '{default: '0};
  logic [EW-1:0]   exp_q [$];    // writes the DUT must present, by cycle
  logic [EW-1:0]   pend_q [$];   // writes the model commits, by cycle

  bit              rq_v [NREQ];
  logic [AW-1:0]   rq_ws [NREQ];
  logic [DW-1:0]   rq_data [NREQ];
  bit              iss_v = 0;
  logic [AW-1:0]   iss_ws = '0;
  logic [AW-1:0]   rs1 = '0;
  logic [AW-1:0]   rs2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      REQ_V[i]                = rq_v[i];
      REQ_WS[i*AW +: AW]      = rq_ws[i];
      REQ_DATA[i*DW +: DW]    = rq_data[i];
    end
    ISSUE_V  = iss_v;
    ISSUE_WS = iss_ws;
    RS1      = rs1;
    RS2      = rs2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ws, input logic [DW-1:0] d);
    if (!rq_v[i]) begin
      rq_v[i]    = 1'b1;
      rq_ws[i]   = ws;
      rq_data[i] = d;
    end
  endtask

  // Called just after a rising edge; runs one cycle of stimulus, checks
  // combinational outputs mid-cycle and advances the model over the edge.
  task automatic step();
    int              gi;
    int              idx;
    logic [NREQ-1:0] erdy;
    bit              h1, h2, st;
    logic [EW-1:0]   e;
    drive_inputs();
    #3;
    gi = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      if (gi < 0 && rq_v[idx]) gi = idx;
    end
    erdy = '0;
    if (gi >= 0) erdy[gi] = 1'b1;
    h1 = busy_m[rs1];
    h2 = busy_m[rs2];
    st = iss_v && (busy_m[iss_ws] || h1 || h2);
    chk("req_rdy", 32'(REQ_RDY), 32'(erdy));
    chk("haz1",    32'(HAZ1),    32'(h1));
    chk("haz2",    32'(HAZ2),    32'(h2));
    chk("stall",   32'(STALL),   32'(st));
    if (gi >= 0) begin
      ptr_m = (gi + 1) % NREQ;
      if (rq_ws[gi] != '0) begin
        e = {16'(cyc + 1), rq_ws[gi], rq_data[gi]};
        exp_q.push_back(e);
        pend_q.push_back(e);
      end
      rq_v[gi] = 1'b0;
    end
    while (pend_q.size() > 0 && pend_q[0][EW-1 -: 16] == 16'(cyc)) begin
      e = pend_q.pop_front();
      rf_m[e[DW+AW-1:DW]]   = e[DW-1:0];
      busy_m[e[DW+AW-1:DW]] = 1'b0;
    end
    if (iss_v && !st && iss_ws != '0) busy_m[iss_ws] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    ptr_m  = 0;
    busy_m = '0;
    drive_inputs();
    repeat (n) begin
      #3;
      chk("rst_req_rdy", 32'(REQ_RDY), 32'(0));
      chk("rst_we",      32'(WE),      32'(0));
      chk("rst_haz1",    32'(HAZ1),    32'(0));
      chk("rst_haz2",    32'(HAZ2),    32'(0));
      chk("rst_stall",   32'(STALL),   32'(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: every cycle the write port must match the queue head
  // scheduled for this cycle, or be idle.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      chk("wb_we", 32'(WE), 32'(1));
      chk("wb_ws", 32'(WS), 32'(e[DW+AW-1:DW]));
      chk("wb_in", 32'(IN), 32'(e[DW-1:0]));
    end else begin
      chk("wb_idle_we", 32'(WE), 32'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rq_v[i] = 1'b0; rq_ws[i] = '0; rq_data[i] = '0;
    end

    // Reset with all requesters valid.
    set_req(REQ_ALU, 3'd1, 16'h1234);
    set_req(REQ_LSU, 3'd2, 16'hBEEF);
    set_req(REQ_PC,  3'd3, 16'hDEAD);
    @(posedge clk);
    #1;
    do_reset(3);

    // Continuous requests: round-robin grants back to back.
    repeat (4) begin
      set_req(REQ_ALU, 3'd1, 16'h1234);
      set_req(REQ_LSU, 3'd2, 16'hBEEF);
      set_req(REQ_PC,  3'd3, 16'hDEAD);
      step();
    end
    repeat (4) step();

    // RAW on R3.
    iss_v = 1; iss_ws = 3'd3; rs1 = 3'd0; rs2 = 3'd0;
    step();
    iss_v = 0; rs1 = 3'd3;
    step();
    set_req(REQ_ALU, 3'd3, 16'hDEAD);
    repeat (3) step();
    chk("rf_r3", 32'(rf_dut[3]), 32'(16'hDEAD));

    // WAW on R4: issue held until the older write retires.
    rs1 = 3'd0;
    iss_v = 1; iss_ws = 3'd4;
    repeat (3) step();
    set_req(REQ_LSU, 3'd4, 16'h1111);
    repeat (3) step();
    iss_v = 0; rs1 = 3'd4;
    step();
    set_req(REQ_ALU, 3'd4, 16'h2222);
    repeat (3) step();

    // Set wins over a coincident clear on R5.
    rs1 = 3'd0;
    set_req(REQ_PC, 3'd5, 16'h5555);
    step();
    iss_v = 1; iss_ws = 3'd5;
    step();
    iss_v = 0; rs1 = 3'd5;
    step();
    chk("busy5_after_coincident", 32'(HAZ1), 32'(1));
    set_req(REQ_PC, 3'd5, 16'h5556);
    repeat (3) step();

    // Write to R0 is consumed without a register-file write.
    rs1 = 3'd0;
    set_req(REQ_ALU, 3'd0, 16'hFFFF);
    repeat (3) step();
    chk("rf_r0", 32'(rf_dut[0]), 32'(0));

    // Reset while an accepted write to R2 is in flight.
    iss_v = 1; iss_ws = 3'd6;
    step();
    iss_v = 0;
    set_req(REQ_PC, 3'd2, 16'hABCD);
    step();
    do_reset(2);
    for (int r = 0; r < NREG; r++) begin
      rs1 = AW'(r);
      rs2 = AW'(NREG - 1 - r);
      step();
    end
    chk("rf_r2_kept", 32'(rf_dut[2]), 32'(16'hBEEF));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq_v[i] && $urandom_range(0, 1) == 1)
          set_req(i, AW'($urandom_range(0, NREG - 1)), DW'($urandom));
      end
      iss_v  = ($urandom_range(0, 9) < 4);
      iss_ws = AW'($urandom_range(0, NREG - 1));
      rs1    = AW'($urandom_range(0, NREG - 1));
      rs2    = AW'($urandom_range(0, NREG - 1));
      step();
    end
    iss_v = 0;
    repeat (8) step();

    for (int r = 0; r < NREG; r++) begin
      chk($sformatf("rf_final_r%0d", r), 32'(rf_dut[r]), 32'(rf_m[r]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_wb_arbiter
